cic_interp: RTL
===============

Name: cic_interp

Overview:
- Cascaded integrator-comb interpolator; the transmit-direction counterpart of the CIC decimator in the DFE filter array.
- Accepts low-rate samples and produces R output samples per input, with R runtime-selectable from {1,2,4,8,16}.
- Structure: comb section at input rate, zero-stuffing upsampler, integrator section at output rate, then gain normalisation.
- Sits after the filter chain, before the DAC-side datapath, in the single 18 MHz clock domain.

Parameters:
- DATA_WIDTH, 16, input/output sample width (signed two's complement).
- ORDER, 4, number of comb and integrator stages (Q), legal 1..5; differential delay fixed at 1.
- LOG2_RMAX, 4, log2 of the largest supported R; internal width W = DATA_WIDTH + ORDER*LOG2_RMAX.

Ports:
- clk  in  1  18 MHz clock.
- rst  in  1  synchronous active-high reset.
- R  in  5  interpolation factor; legal values 1, 2, 4, 8, 16; any other value is treated as 1.
- in_data  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  DATA_WIDTH  signed interpolated sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high while EMIT state is active or out_valid is high.

Behaviour:
- Reset (rst=1 at clk edge): all comb delays, integrator accumulators, phase counter and output register cleared to 0; state=IDLE; in_ready=1; out_valid=0; out_data=0; busy=0.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1.
  - Input handshake occurs when in_valid=1.
  - On handshake: R latched as r_lat (log2 stored as L); sign-extended in_data pushed through the comb cascade (c_k = x_k - x_k_delayed), registered as comb_out, phase=0, state goes to EMIT.
- EMIT:
  - in_ready=0.
  - A step occurs in any cycle where out_valid=0 or out_ready=1.
  - On each step: u = comb_out when phase==0, else 0 (zero-stuffing).
  - Integrators update as a same-cycle cascade: a1'=a1+u, a_k'=a_k+a_(k-1)'.
  - out_data <= a_ORDER' arithmetic-shifted right by (ORDER-1)*L, truncated to DATA_WIDTH; out_valid <= 1.
  - phase increments on each step; after the step with phase==r_lat-1, state returns to IDLE.
- Output register: if out_valid=1 and out_ready=0, out_data and out_valid hold and no step occurs (backpressure). out_valid clears after acceptance when no new step loads it.
- Latency: input handshake at cycle t, first out_valid at cycle t+2. With out_ready held at 1, one output per cycle for R cycles. The next input can be accepted the cycle after the last step.
- Wraparound: all internal arithmetic is modulo 2^W. Integrator overflow is intentional and cancelled by the combs.
- Gain: the DC gain of R^(ORDER-1) is removed exactly by the shift. With R=1 the output equals the input delayed.
- R change:
  - R is sampled only at input handshake; changes mid-burst are ignored.
  - If the latched R differs from the previous latched R, comb delays and integrators are zeroed in the same cycle before the new sample is processed.
- Reset mid-burst: the burst is aborted, outputs go to their reset values immediately, and a partially accepted sample is discarded.
- Simultaneous in_valid and reset: reset wins; no handshake occurs.

Optional Feature:
- Macro: CIC_INT_ROUND_EN.
- Defined: before the shift, add 2^((ORDER-1)*L-1) when the shift is greater than 0 (round half up). Then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: plain arithmetic-shift truncation (floor), no saturation logic.

Test Plan:
- Reset, then R=1, inputs 100, -200, 32767 -> outputs 100, -200, 32767, each 2 cycles after its handshake; exactly one output per input.
- R=2, ORDER=4, impulse 8000 followed by zeros, out_ready=1 -> outputs 1000, 4000, 6000, 4000, 1000, then 0s.
- R=4, ORDER=4, constant input 1000 -> after settling, every output equals 1000; 4 outputs per input; in_ready low for 4 cycles per burst.
- R=2 impulse 8000 with out_ready low for 3 cycles on the 2nd output -> out_data holds 4000 with out_valid=1; sequence otherwise unchanged.
- R=2, ORDER=4, impulse 3 -> without macro: 0, 1, 2, 1, 0; with CIC_INT_ROUND_EN: 0, 2, 2, 2, 0.
- Mid-burst R change from 8 to 2, then rst pulse during a burst -> R change takes effect only on the next handshake and clears state; rst forces out_valid=0, in_ready=1, out_data=0 on the next cycle.

Source files
------------

// File: rtl/cic_interp.sv
// CIC interpolator: input-rate comb cascade, zero-stuffing by R, output-rate integrator cascade, gain shift.
// Optional CIC_INT_ROUND_EN: round half up before the shift and saturate to DATA_WIDTH.
module cic_interp #(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 4,
  parameter int LOG2_RMAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            R,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int W    = DATA_WIDTH + ORDER*LOG2_RMAX;
  localparam int PW   = (LOG2_RMAX > 0) ? LOG2_RMAX : 1;
  localparam int LW   = (LOG2_RMAX < 1) ? 1 : $clog2(LOG2_RMAX+1);
  localparam int SMAX = (ORDER-1)*LOG2_RMAX;
  localparam int SW   = (SMAX < 1) ? 1 : $clog2(SMAX+1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                   r_state;
  logic [LW-1:0]            r_l;
  logic [PW-1:0]            r_last;
  logic [PW-1:0]            r_phase;
  logic [ORDER-1:0][W-1:0]  r_dly;
  logic [ORDER-1:0][W-1:0]  r_acc;
  logic [W-1:0]             r_comb;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic                     r_out_valid;

  logic [LW-1:0]            w_l_new;
  logic [PW-1:0]            w_last_new;
  logic                     w_clr;
  logic                     w_step;
  logic [ORDER:0][W-1:0]    w_c;
  logic [ORDER-1:0][W-1:0]  w_d;
  logic [ORDER:0][W-1:0]    w_s;
  logic [SW-1:0]            w_sh;
  logic signed [W-1:0]      w_ys;
  logic signed [W-1:0]      w_q;
  logic [DATA_WIDTH-1:0]    w_res;

  // Unsupported R values collapse to R=1 (L=0).
  always_comb begin
    w_l_new = '0;
    case (R)
      5'd2:    w_l_new = LW'(1);
      5'd4:    w_l_new = LW'(2);
      5'd8:    w_l_new = LW'(3);
      5'd16:   w_l_new = LW'(4);
      default: w_l_new = '0;
    endcase
    if (int'(w_l_new) > LOG2_RMAX) w_l_new = '0;
  end

  assign w_last_new = PW'((1 << w_l_new) - 1);
  assign w_clr      = (w_l_new != r_l);
  assign w_step     = (r_state == S_EMIT) && (!r_out_valid || out_ready);

  // A new R starts the filter from a clean state, so the comb sees zero history.
  assign w_c[0] = W'($signed(in_data));
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    assign w_d[k]   = w_clr ? '0 : r_dly[k];
    assign w_c[k+1] = w_c[k] - w_d[k];
  end

  assign w_s[0] = (r_phase == '0) ? r_comb : '0;
  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    assign w_s[k+1] = r_acc[k] + w_s[k];
  end

  assign w_sh = SW'(int'(r_l) * (ORDER-1));
  assign w_ys = w_s[ORDER];

`ifdef CIC_INT_ROUND_EN
  localparam logic signed [W-1:0] SMAXV = W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [W-1:0] SMINV = -SMAXV - W'(1);
  logic signed [W-1:0] w_bias;
  assign w_bias = (w_sh == '0) ? '0 : (W'(1) << (w_sh - SW'(1)));
  assign w_q    = (w_ys + w_bias) >>> w_sh;
  always_comb begin
    w_res = w_q[DATA_WIDTH-1:0];
    if (w_q > SMAXV)      w_res = SMAXV[DATA_WIDTH-1:0];
    else if (w_q < SMINV) w_res = SMINV[DATA_WIDTH-1:0];
  end
`else
  logic w_unused;
  assign w_q      = w_ys >>> w_sh;
  assign w_res    = w_q[DATA_WIDTH-1:0];
  assign w_unused = &{1'b0, w_q[W-1:DATA_WIDTH]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_l         <= '0;
      r_last      <= '0;
      r_phase     <= '0;
      r_dly       <= '0;
      r_acc       <= '0;
      r_comb      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_l     <= w_l_new;
            r_last  <= w_last_new;
            for (int k = 0; k < ORDER; k++) r_dly[k] <= w_c[k];
            r_comb  <= w_c[ORDER];
            if (w_clr) r_acc <= '0;
            r_phase <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_step) begin
            r_acc       <= w_s[ORDER:1];
            r_out_data  <= w_res;
            r_out_valid <= 1'b1;
            r_phase     <= r_phase + PW'(1);
            if (r_phase == r_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_EMIT) | r_out_valid;
endmodule
